// File: rtl/sr_mem_arbiter.sv
// Two-master arbiter for the shared data-memory port; one access in flight at a time.
// Round-robin by default; define SR_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module sr_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, stateNext;
  logic [3:0] cnt;
  logic       owner;
  logic       we;
  logic       winner;
  logic       grant;

`ifdef SR_ARB_FIXED_PRIO_EN
  assign winner = ~m0_req;
`else
  logic lastOwner;

  // On a tie the port that did not win last time goes next.
  assign winner = (m0_req && m1_req) ? ~lastOwner : m1_req;

  always_ff @(posedge clk) begin
    if (rst)        lastOwner <= 1'b1;
    else if (grant) lastOwner <= winner;
  end
`endif

  assign grant     = !rst && (state == IDLE) && (m0_req || m1_req);
  assign m0_gnt    = grant && !winner;
  assign m1_gnt    = grant && winner;
  assign m0_rvalid = (state == RESP) && !owner;
  assign m1_rvalid = (state == RESP) && owner;
  assign busy      = (state != IDLE);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:        if (m0_req || m1_req) stateNext = ISSUE;
      ISSUE, WAIT: stateNext = (cnt == 4'd0) ? RESP : WAIT;
      RESP:        stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      we        <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state   <= stateNext;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      if (grant) begin
        // Request fields go straight into the memory-side registers so ISSUE drives them.
        owner     <= winner;
        we        <= winner ? m1_we : m0_we;
        mem_req   <= 1'b1;
        mem_we    <= winner ? m1_we : m0_we;
        mem_addr  <= winner ? m1_addr : m0_addr;
        mem_wdata <= winner ? m1_wdata : m0_wdata;
        cnt       <= 4'(MEM_LAT);
      end
      if (state == ISSUE || state == WAIT) begin
        if (cnt == 4'd0) begin
          if (owner) m1_rdata <= we ? '0 : mem_rdata;
          else       m0_rdata <= we ? '0 : mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/sr_mem_arbiter.md
Name: sr_mem_arbiter

Overview:
- Shares the single general data-memory port between two masters.
  - Port 0: CPU load/store path.
  - Port 1: secondary master, e.g. debug loader or DMA.
- Sits between the masters and the memory.
- Sequences each access through a fixed-latency memory model.
- Serialises accesses: exactly one transaction outstanding at a time.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from the mem_req cycle to mem_rdata valid. Legal range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  port 0 request; held with stable fields until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  AW  port 0 address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 request accepted (1-cycle pulse)
- m0_rvalid  out  1  port 0 completion (1-cycle pulse)
- m0_rdata  out  DW  port 0 read data, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_req  out  1  memory access strobe (1 cycle)
- mem_we  out  1  memory write enable, qualified by mem_req
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_req
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - rst is synchronous, active-high, sampled on posedge clk.
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrates among the asserted reqs.
  - The winner's mX_gnt is driven combinationally high in the same cycle.
  - The winner's we/addr/wdata and owner id are latched.
  - Next state: ISSUE.
  - With no req, stays in IDLE with all gnt = 0.
- Arbitration:
  - Round-robin on a last_owner register, which is updated at each grant.
  - If only one port requests, that port wins.
  - If both request, the port != last_owner wins.
  - last_owner resets to 1, so port 0 wins the first tie.
- ISSUE:
  - mem_req = 1 for exactly this cycle.
  - mem_we/mem_addr/mem_wdata are driven from the latched values.
  - Counter loaded with MEM_LAT.
- ISSUE/WAIT step, evaluated each cycle:
  - cnt == 0: capture mem_rdata (reads only; writes capture 0), then go to RESP.
  - Otherwise: cnt <= cnt - 1, then go to WAIT.
- RESP:
  - Owner's mX_rvalid = 1 and mX_rdata = captured data, for one cycle.
  - Writes also get rvalid, with rdata = 0.
  - Next state: IDLE.
- Latency: for a grant in cycle G, mem_req is in cycle G+1 and rvalid is in cycle G+2+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles. No grant is issued outside IDLE, even while the other port is waiting.
- Non-owner port: rvalid is never asserted; rdata holds its last value.
- Reset values:
  - All gnt and rvalid = 0.
  - Both mX_rdata = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, cnt = 0.
- Register timing:
  - mem_addr and mem_wdata are registered; they hold their value after ISSUE until the next ISSUE.
  - mem_we is 0 whenever mem_req is 0.
- Reset mid-operation:
  - Returns to IDLE next cycle.
  - The in-flight transaction is dropped: no rvalid; mem_req/mem_we cleared.
  - gnt is 0 during any cycle where rst = 1.
- A req deasserted before gnt is legal. The request is withdrawn and nothing is issued.
- A port re-asserting req in its own RESP cycle is not granted until the following IDLE cycle.

Optional Feature:
- Macro: SR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins a tie; last_owner is unused and may be removed. Port 1 can starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- MEM_LAT=2, m0 read addr 0x40, memory returns 0xDEADBEEF → m0_gnt in cycle G; mem_req=1, mem_we=0, mem_addr=0x40 in G+1; m0_rvalid=1, m0_rdata=0xDEADBEEF in G+4; busy high G+1..G+4.
- MEM_LAT=0, m1 write addr 0x10 data 0x12345678 → mem_req=1, mem_we=1, mem_wdata=0x12345678 in G+1; m1_rvalid=1, m1_rdata=0 in G+2; m0 signals stay 0.
- Both ports request continuously after reset (round-robin build) → grants alternate m0, m1, m0, m1, spaced MEM_LAT+3 cycles apart; each rvalid goes only to its owner.
- Same stimulus with SR_ARB_FIXED_PRIO_EN defined → every grant goes to m0; m1_gnt stays 0 until m0_req drops, then m1 is granted in the next IDLE cycle.
- MEM_LAT=3, m0 read granted, rst=1 during the first WAIT cycle → next cycle IDLE, busy=0, all outputs at reset values, no m0_rvalid ever asserted; a fresh m1 req afterwards completes normally.
- m0_req asserted for one cycle while state=WAIT (serving m1), then dropped → no m0_gnt and no second mem_req; only m1's transaction completes.
